// File: rtl/fdma_reset_responder_pkg.sv
// Shared types for the FDMA reset responder: FSM state encoding and counter width helper.
// Imported by the top and by the outstanding-burst counter.
package fdma_reset_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLOCK = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RESET = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bits needed to hold 0..max_osd inclusive.
  function automatic int osd_w(input int max_osd);
    return $clog2(max_osd + 1);
  endfunction

endpackage

// File: rtl/fdma_reset_responder_axi_osd_counter.sv
// Outstanding-burst counter for one AXI direction: saturates at MAX_OSD, clamps at 0.
// Simultaneous inc/dec leaves the count unchanged; clr has priority over both.
module axi_osd_counter
  import fdma_reset_responder_pkg::*;
#(
  parameter int MAX_OSD = 8,
  localparam int OSD_W = osd_w(MAX_OSD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [OSD_W-1:0] cnt
);

  localparam logic [OSD_W-1:0] MAX_CNT = OSD_W'(MAX_OSD);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fdma_reset_responder.sv
// Drains outstanding FDMA AXI bursts on a field reset request, then pulses a clean engine reset.
// Optional DRAIN watchdog and o_Timeout port are enabled by defining FDMA_RST_TIMEOUT_EN.
module fdma_reset_responder
  import fdma_reset_responder_pkg::*;
#(
  parameter int RST_LEN       = 16,
  parameter int MAX_OSD       = 8
`ifdef FDMA_RST_TIMEOUT_EN
  ,
  parameter int DRAIN_TIMEOUT = 4096
`endif
) (
  input  logic i_Sys_clk,
  input  logic i_Rst_n,
  input  logic i_Axi_reset,
  input  logic i_Aw_valid,
  input  logic i_Aw_ready,
  input  logic i_B_valid,
  input  logic i_B_ready,
  input  logic i_Ar_valid,
  input  logic i_Ar_ready,
  input  logic i_R_valid,
  input  logic i_R_ready,
  input  logic i_R_last,
`ifdef FDMA_RST_TIMEOUT_EN
  output logic o_Timeout,
`endif
  output logic o_Req_block,
  output logic o_Fdma_rst,
  output logic o_Rst_done,
  output logic o_Busy
);

  localparam int OSD_W = osd_w(MAX_OSD);
  localparam int RST_W = $clog2(RST_LEN + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_LEN - 1);

  state_t state;
  state_t state_nxt;

  logic             axi_reset_d1;
  logic             req;
  logic [RST_W-1:0] rst_cnt;
  logic [OSD_W-1:0] wr_cnt;
  logic [OSD_W-1:0] rd_cnt;
  logic             drained;

  logic req_block_nxt;
  logic fdma_rst_nxt;
  logic rst_done_nxt;
  logic busy_nxt;

  assign req     = i_Axi_reset & ~axi_reset_d1;
  assign drained = (wr_cnt == '0) && (rd_cnt == '0);

  // Counters run in every state so a handshake landing on the block edge is still tracked.
  axi_osd_counter #(.MAX_OSD(MAX_OSD)) u_wr_cnt (
    .clk   (i_Sys_clk),
    .rst_n (i_Rst_n),
    .inc   (i_Aw_valid & i_Aw_ready),
    .dec   (i_B_valid & i_B_ready),
    .clr   (o_Fdma_rst),
    .cnt   (wr_cnt)
  );

  axi_osd_counter #(.MAX_OSD(MAX_OSD)) u_rd_cnt (
    .clk   (i_Sys_clk),
    .rst_n (i_Rst_n),
    .inc   (i_Ar_valid & i_Ar_ready),
    .dec   (i_R_valid & i_R_ready & i_R_last),
    .clr   (o_Fdma_rst),
    .cnt   (rd_cnt)
  );

`ifdef FDMA_RST_TIMEOUT_EN
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  logic [TO_W-1:0] drain_cnt;
  logic            timeout_hit;

  assign timeout_hit = (state == ST_DRAIN) && !drained && (drain_cnt == TO_LAST);

  always_ff @(posedge i_Sys_clk) begin
    if (!i_Rst_n) begin
      drain_cnt <= '0;
      o_Timeout <= 1'b0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if ((state == ST_IDLE) && req) begin
        o_Timeout <= 1'b0;
      end else if (timeout_hit) begin
        o_Timeout <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_Sys_clk) begin
    if (!i_Rst_n) begin
      state        <= ST_IDLE;
      axi_reset_d1 <= 1'b0;
      rst_cnt      <= '0;
      o_Req_block  <= 1'b0;
      o_Fdma_rst   <= 1'b0;
      o_Rst_done   <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      state        <= state_nxt;
      axi_reset_d1 <= i_Axi_reset;
      rst_cnt      <= (state == ST_RESET) ? rst_cnt + 1'b1 : '0;
      o_Req_block  <= req_block_nxt;
      o_Fdma_rst   <= fdma_rst_nxt;
      o_Rst_done   <= rst_done_nxt;
      o_Busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req) state_nxt = ST_BLOCK;
      ST_BLOCK: state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (drained) begin
          state_nxt = ST_RESET;
`ifdef FDMA_RST_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_nxt = ST_RESET;
`endif
        end
      end
      ST_RESET: if (rst_cnt == RST_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from the next state so each registered output moves with the state itself.
  always_comb begin
    req_block_nxt = (state_nxt == ST_BLOCK) || (state_nxt == ST_DRAIN) || (state_nxt == ST_RESET);
    fdma_rst_nxt  = (state_nxt == ST_RESET);
    rst_done_nxt  = (state_nxt == ST_DONE);
    busy_nxt      = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_fdma_reset_responder.sv
// Directed bench for fdma_reset_responder: vector table for request timing, hand sequences for drain/counters/abort.
module tb_fdma_reset_responder;

  localparam int RL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic axi_reset = 1'b0;
  logic aw_v = 1'b0, aw_r = 1'b0, b_v = 1'b0, b_r = 1'b0;
  logic ar_v = 1'b0, ar_r = 1'b0, r_v = 1'b0, r_r = 1'b0, r_last = 1'b0;
  logic req_block, fdma_rst, rst_done, busy;
`ifdef FDMA_RST_TIMEOUT_EN
  logic timeout;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fdma_reset_responder #(
    .RST_LEN(RL),
    .MAX_OSD(8)
`ifdef FDMA_RST_TIMEOUT_EN
    ,
    .DRAIN_TIMEOUT(100)
`endif
  ) dut (
    .i_Sys_clk  (clk),
    .i_Rst_n    (rst_n),
    .i_Axi_reset(axi_reset),
    .i_Aw_valid (aw_v),
    .i_Aw_ready (aw_r),
    .i_B_valid  (b_v),
    .i_B_ready  (b_r),
    .i_Ar_valid (ar_v),
    .i_Ar_ready (ar_r),
    .i_R_valid  (r_v),
    .i_R_ready  (r_r),
    .i_R_last   (r_last),
`ifdef FDMA_RST_TIMEOUT_EN
    .o_Timeout  (timeout),
`endif
    .o_Req_block(req_block),
    .o_Fdma_rst (fdma_rst),
    .o_Rst_done (rst_done),
    .o_Busy     (busy)
  );

  typedef struct {
    logic       axi;
    logic [3:0] exp;  // {req_block, fdma_rst, rst_done, busy}
  } vec_t;

  vec_t tbl[88];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs k cycles after a request first seen with nothing outstanding.
  function automatic logic [3:0] seq_exp(input int k);
    logic b, r, d, y;
    b = (k >= 1) && (k <= 2 + RL);
    r = (k >= 3) && (k <= 2 + RL);
    d = (k == 3 + RL);
    y = (k >= 1) && (k <= 3 + RL);
    return {b, r, d, y};
  endfunction

  function automatic logic [3:0] outs();
    return {req_block, fdma_rst, rst_done, busy};
  endfunction

  initial begin
    // Pulse at 10 plus a second edge at 16 (inside RESET, must be ignored).
    for (int k = 0; k < 40; k++) begin
      tbl[k].axi = (k == 10) || (k == 16);
      tbl[k].exp = seq_exp(k + 1 - 10);
    end
    // Level held high for 40 cycles: exactly one sequence.
    for (int k = 0; k < 48; k++) begin
      tbl[40 + k].axi = (k < 40);
      tbl[40 + k].exp = seq_exp(k + 1);
    end

    tick();
    tick();
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_wr", 32'(dut.wr_cnt), 32'd0);
    chk("reset_rd", 32'(dut.rd_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 88; i++) begin
      axi_reset = tbl[i].axi;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    axi_reset = 1'b0;
    tick();

    // Drain wait: 2 AW + 1 AR outstanding before the request.
    aw_v = 1'b1; aw_r = 1'b1;
    tick();
    tick();
    aw_v = 1'b0; aw_r = 1'b0; ar_v = 1'b1; ar_r = 1'b1;
    tick();
    ar_v = 1'b0; ar_r = 1'b0; aw_v = 1'b1;
    tick();
    aw_v = 1'b0;
    chk("drain_wr2", 32'(dut.wr_cnt), 32'd2);
    chk("drain_rd1", 32'(dut.rd_cnt), 32'd1);
    axi_reset = 1'b1;
    tick();
    axi_reset = 1'b0;
    chk("drain_blk", 32'(req_block), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("drain_hold", 32'({fdma_rst, busy}), 32'b01);
    end
    r_v = 1'b1; r_r = 1'b1;
    tick();
    r_v = 1'b0; r_r = 1'b0;
    chk("drain_rnolast", 32'(dut.rd_cnt), 32'd1);
    b_v = 1'b1; b_r = 1'b1;
    tick();
    chk("drain_b1", 32'(dut.wr_cnt), 32'd1);
    tick();
    b_v = 1'b0; b_r = 1'b0;
    chk("drain_b2", 32'({dut.wr_cnt, fdma_rst}), 32'({4'd0, 1'b0}));
    r_v = 1'b1; r_r = 1'b1; r_last = 1'b1;
    tick();
    r_v = 1'b0; r_r = 1'b0; r_last = 1'b0;
    chk("drain_rlast", 32'({dut.rd_cnt, fdma_rst}), 32'({4'd0, 1'b0}));
    tick();
    chk("drain_rst_on", 32'(fdma_rst), 32'd1);
    repeat (RL) tick();
    chk("drain_done", 32'(outs()), 32'b0011);
    tick();
    chk("drain_idle", 32'(outs()), 32'h0);

    // Counter corner cases.
    aw_v = 1'b1; aw_r = 1'b1;
    repeat (3) tick();
    chk("cnt_wr3", 32'(dut.wr_cnt), 32'd3);
    b_v = 1'b1; b_r = 1'b1;
    tick();
    b_v = 1'b0; b_r = 1'b0;
    chk("cnt_simul", 32'(dut.wr_cnt), 32'd3);
    repeat (5) tick();
    chk("cnt_wr8", 32'(dut.wr_cnt), 32'd8);
    tick();
    aw_v = 1'b0; aw_r = 1'b0;
    chk("cnt_sat", 32'(dut.wr_cnt), 32'd8);
    r_v = 1'b1; r_r = 1'b1; r_last = 1'b1;
    tick();
    r_v = 1'b0; r_r = 1'b0; r_last = 1'b0;
    chk("cnt_clamp0", 32'(dut.rd_cnt), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("cnt_rst_clear", 32'(dut.wr_cnt), 32'd0);

    // Abort in RESET via i_Rst_n.
    axi_reset = 1'b1;
    tick();
    axi_reset = 1'b0;
    repeat (3) tick();
    chk("abort_in_rst", 32'(outs()), 32'b1101);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_outs", 32'(outs()), 32'h0);
    chk("abort_cnts", 32'({dut.wr_cnt, dut.rd_cnt}), 32'h0);
    repeat (3) tick();
    chk("abort_stay_idle", 32'(outs()), 32'h0);

`ifdef FDMA_RST_TIMEOUT_EN
    aw_v = 1'b1; aw_r = 1'b1;
    tick();
    aw_v = 1'b0; aw_r = 1'b0;
    axi_reset = 1'b1;
    tick();
    axi_reset = 1'b0;
    repeat (100) tick();
    chk("to_before", 32'({fdma_rst, timeout}), 32'b00);
    tick();
    chk("to_forced", 32'({fdma_rst, timeout}), 32'b11);
    repeat (20) tick();
    chk("to_sticky", 32'({busy, timeout}), 32'b01);
    axi_reset = 1'b1;
    tick();
    axi_reset = 1'b0;
    chk("to_cleared", 32'({busy, timeout}), 32'b10);
    repeat (24) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
